approxmul_16bit: RTL and testbench

- Registered approximate unsigned 8x8 multiplier producing a 16-bit product.
- The lower APPROX_COLS columns of the partial-product matrix use carry-free OR compression; all higher columns are summed exactly.
- Used in error-tolerant datapaths for area and delay savings. A bench can sweep all 65536 operand pairs and count exact and inexact results.

---
 rtl/approxmul_16bit.sv | 102 ++++++++++
 tb/tb_approxmul_16bit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/approxmul_16bit.sv
// Registered approximate 8x8 unsigned multiplier: low APPROX_COLS product
// columns are OR-compressed (carry-free); upper columns are summed exactly.
module approxmul_16bit #(
  parameter int unsigned APPROX_COLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        valid_o,
  output logic [15:0] p
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam logic [PROD_W-1:0] HI_MASK = PROD_W'({PROD_W{1'b1}} << APPROX_COLS);

  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
    return PROD_W'(((x & y) | (x & z) | (y & z)) << 1);
  endfunction

  logic [PROD_W-1:0] row [OP_W];
  logic [PROD_W-1:0] lo_bits;

  // Shifted partial-product rows, with the approximate columns cleared out.
  always_comb begin
    for (int unsigned j = 0; j < OP_W; j++) begin
      row[j] = PROD_W'({8'd0, a & {OP_W{b[j]}}} << j) & HI_MASK;
    end
  end

  // Carry-free OR compression of each low column.
  always_comb begin
    lo_bits = '0;
    for (int unsigned i = 0; i < OP_W; i++) begin
      for (int unsigned j = 0; j < OP_W; j++) begin
        if (i + j < APPROX_COLS) begin
          lo_bits[4'(i + j)] = lo_bits[4'(i + j)] | (a[i] & b[j]);
        end
      end
    end
  end

  // Wallace-style 3:2 reduction, 8 rows -> 2, then a final carry-propagate add.
  logic [PROD_W-1:0] s0, c0, s1, c1;
  logic [PROD_W-1:0] s2, c2, s3, c3;
  logic [PROD_W-1:0] s4, c4;
  logic [PROD_W-1:0] s5, c5;
  logic [PROD_W-1:0] hi_sum;

  always_comb begin
    s0 = csa_sum  (row[0], row[1], row[2]);
    c0 = csa_carry(row[0], row[1], row[2]);
    s1 = csa_sum  (row[3], row[4], row[5]);
    c1 = csa_carry(row[3], row[4], row[5]);

    s2 = csa_sum  (s0, c0, s1);
    c2 = csa_carry(s0, c0, s1);
    s3 = csa_sum  (c1, row[6], row[7]);
    c3 = csa_carry(c1, row[6], row[7]);

    s4 = csa_sum  (s2, c2, s3);
    c4 = csa_carry(s2, c2, s3);

    s5 = csa_sum  (s4, c4, c3);
    c5 = csa_carry(s4, c4, c3);

    // The true sum is below 2^16, so dropping the top carry is lossless.
    hi_sum = s5 + c5;
  end

  logic [PROD_W-1:0] p_d, p_q;
  logic              valid_d, valid_q;

  always_comb begin
    p_d     = (hi_sum & HI_MASK) | (lo_bits & ~HI_MASK);
    valid_d = valid_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign p       = p_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_approxmul_16bit.sv
// Bench for approxmul_16bit: directed table, pipeline/reset sequences,
// randomized traffic and an exhaustive sweep for APPROX_COLS=4 and 0.
module tb_approxmul_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  a, b;
  logic        valid4, valid0;
  logic [15:0] p4, p0;

  int tests  = 0;
  int errors = 0;

  approxmul_16bit #(.APPROX_COLS(4)) dut4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .a(a), .b(b),
    .valid_o(valid4), .p(p4)
  );

  approxmul_16bit #(.APPROX_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .a(a), .b(b),
    .valid_o(valid0), .p(p0)
  );

  always #5 clk = ~clk;

  // Column-count model: low columns report "any one set", upper columns add count*2^c.
  function automatic int ref_p(input int x, input int y, input int cols);
    int cnt [16];
    int res;
    for (int c = 0; c < 16; c++) cnt[c] = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (((x >> i) & 1) == 1 && ((y >> j) & 1) == 1) cnt[i + j]++;
    res = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < cols) res += (cnt[c] > 0) ? (1 << c) : 0;
      else          res += cnt[c] * (1 << c);
    end
    return res;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one operand set, let it be captured, sample just after the edge.
  task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y);
    valid_i = v; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp4;
    logic [15:0] exp0;
  } vec_t;

  vec_t vecs [7];
  int   exact_cnt;
  int   inexact_cnt;
  int   model_exact_cnt;
  int   pr;

  initial begin
    vecs[0] = '{8'd0,   8'd200, 16'd0,     16'd0};
    vecs[1] = '{8'd1,   8'd1,   16'd1,     16'd1};
    vecs[2] = '{8'd16,  8'd16,  16'd256,   16'd256};
    vecs[3] = '{8'd2,   8'd8,   16'd16,    16'd16};
    vecs[4] = '{8'd3,   8'd3,   16'd7,     16'd9};
    vecs[5] = '{8'd15,  8'd15,  16'd191,   16'd225};
    vecs[6] = '{8'd255, 8'd255, 16'd64991, 16'd65025};

    // Reset held with live operands: outputs stay cleared across edges.
    rst = 1'b1; valid_i = 1'b1; a = 8'hFF; b = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p", int'(p4), 0);
    chk("reset_valid", int'(valid4), 0);
    chk("reset_p_exact", int'(p0), 0);

    // First result after release comes from the first sampled operands.
    rst = 1'b0;
    step(1'b1, 8'hFF, 8'hFF);
    chk("post_reset_p", int'(p4), 64991);
    chk("post_reset_valid", int'(valid4), 1);

    // Asynchronous reset mid-cycle clears outputs before any edge.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_p", int'(p4), 0);
    chk("async_rst_valid", int'(valid4), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[k]) begin
      step(1'b1, vecs[k].a, vecs[k].b);
      chk($sformatf("tbl%0d_p4", k), int'(p4), int'(vecs[k].exp4));
      chk($sformatf("tbl%0d_p0", k), int'(p0), int'(vecs[k].exp0));
      chk($sformatf("tbl%0d_valid", k), int'(valid4), 1);
    end

    // Back-to-back pipeline, then valid_i drop.
    step(1'b1, 8'd3, 8'd3);
    chk("pipe0_p", int'(p4), 7);
    chk("pipe0_valid", int'(valid4), 1);
    step(1'b1, 8'd15, 8'd15);
    chk("pipe1_p", int'(p4), 191);
    chk("pipe1_valid", int'(valid4), 1);
    step(1'b1, 8'd1, 8'd1);
    chk("pipe2_p", int'(p4), 1);
    chk("pipe2_valid", int'(valid4), 1);
    step(1'b0, 8'd3, 8'd3);
    chk("drop_valid", int'(valid4), 0);
    chk("drop_p_still_updates", int'(p4), 7);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic       v;
      logic [7:0] x, y;
      v = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = 8'($urandom);
      step(v, x, y);
      chk("rand_p4", int'(p4), ref_p(int'(x), int'(y), 4));
      chk("rand_p0", int'(p0), int'(x) * int'(y));
      chk("rand_valid", int'(valid4), int'(v));
    end

    // Exhaustive sweep of both configurations.
    exact_cnt = 0;
    inexact_cnt = 0;
    model_exact_cnt = 0;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        step(1'b1, 8'(x), 8'(y));
        pr = ref_p(x, y, 4);
        chk("sweep_p4", int'(p4), pr);
        chk("sweep_p0", int'(p0), x * y);
        if (pr == x * y) model_exact_cnt++;
        if (int'(p4) == x * y) exact_cnt++;
        else                   inexact_cnt++;
      end
    end
    $display("[TB] sweep APPROX_COLS=4: %0d exact, %0d inexact", exact_cnt, inexact_cnt);
    chk("sweep_exact_count", exact_cnt, model_exact_cnt);
    chk("sweep_inexact_count", inexact_cnt, 65536 - model_exact_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
